// File: rtl/mem_bist_pkg.sv
// Shared definitions for the march-test BIST sequencer: state encoding,
// sweep direction and flush length.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_M1_UP  = 3'd2,
    ST_M2_DN  = 3'd3,
    ST_VERIFY = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int FLUSH_LEN = 1;

  function automatic logic sweep_dir(input state_e s);
    return (s == ST_M2_DN) ? DIR_DN : DIR_UP;
  endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-back checker: aligns expected data/enable/address with the memory's
// registered output, then records a sticky fail, first failing address and
// a saturating error count.
module mem_bist_checker
  import mem_bist_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 chk_en_i,
  input  logic [WORD_SIZE-1:0] exp_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] dout_i,
  output logic                 fail_o,
  output logic [ADDR_SIZE-1:0] fail_addr_o,
  output logic [ERR_WIDTH-1:0] err_count_o
);

  logic                 en_p1_q, en_p1_d;
  logic [WORD_SIZE-1:0] exp_p1_q;
  logic [ADDR_SIZE-1:0] addr_p1_q;
  logic                 fail_q, fail_d;
  logic [ADDR_SIZE-1:0] fail_addr_q, fail_addr_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 mismatch;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  assign en_p1_d  = clr_i ? 1'b0 : chk_en_i;
  assign mismatch = en_p1_q && (dout_i != exp_p1_q);

  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_d       = err_q;
    if (clr_i) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      err_d       = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = addr_p1_q;
      err_d = sat_inc(err_q);
    end
  end

  // stage p1: expectation delayed one edge to line up with the memory output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_p1_q     <= 1'b0;
      exp_p1_q    <= '0;
      addr_p1_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_q       <= '0;
    end else begin
      en_p1_q     <= en_p1_d;
      exp_p1_q    <= exp_i;
      addr_p1_q   <= addr_i;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_q       <= err_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/mem_bist.sv
// March-test BIST sequencer for a write-every-cycle, read-old-data memory:
// fill, ascending invert, descending restore, ascending verify.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int          WORD_SIZE = 8,
  parameter int          ADDR_SIZE = 4,
  parameter int unsigned PATTERN   = 32'h55,
  parameter int          ERR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic [ADDR_SIZE-1:0] MEM_ADDR,
  output logic [WORD_SIZE-1:0] MEM_DIN,
  input  logic [WORD_SIZE-1:0] MEM_DOUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [ADDR_SIZE-1:0] FAIL_ADDR,
  output logic [ERR_WIDTH-1:0] ERR_COUNT
);

  localparam logic [WORD_SIZE-1:0] PAT       = WORD_SIZE'(PATTERN);
  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = {ADDR_SIZE{1'b1}};
  localparam logic [1:0]           FLUSH_END = 2'(FLUSH_LEN - 1);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] din_q, din_d;
  logic [WORD_SIZE-1:0] exp_q, exp_d;
  logic                 chk_en_q, chk_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           flush_cnt_q, flush_cnt_d;
  logic                 clr;
  logic                 last;

  assign last = (sweep_dir(state_q) == DIR_DN) ? (addr_q == '0) : (addr_q == ADDR_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    exp_d       = exp_q;
    chk_en_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    flush_cnt_d = flush_cnt_q;
    clr         = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          clr     = 1'b1;
          state_d = ST_FILL;
          addr_d  = '0;
          din_d   = PAT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_FILL: begin
        if (last) begin
          state_d  = ST_M1_UP;
          addr_d   = '0;
          din_d    = ~PAT;
          exp_d    = PAT;
          chk_en_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_SIZE'(1);
        end
      end
      ST_M1_UP: begin
        chk_en_d = 1'b1;
        if (last) begin
          // Same address again: the memory returns the ~P written one edge earlier.
          state_d = ST_M2_DN;
          din_d   = PAT;
          exp_d   = ~PAT;
        end else begin
          addr_d = addr_q + ADDR_SIZE'(1);
        end
      end
      ST_M2_DN: begin
        chk_en_d = 1'b1;
        if (last) begin
          state_d = ST_VERIFY;
          addr_d  = '0;
          din_d   = PAT;
          exp_d   = PAT;
        end else begin
          addr_d = addr_q - ADDR_SIZE'(1);
        end
      end
      ST_VERIFY: begin
        if (last) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else begin
          chk_en_d = 1'b1;
          addr_d   = addr_q + ADDR_SIZE'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_END) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      exp_q       <= '0;
      chk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      exp_q       <= exp_d;
      chk_en_q    <= chk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  mem_bist_checker #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .ERR_WIDTH(ERR_WIDTH)
  ) u_checker (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (clr),
    .chk_en_i   (chk_en_q),
    .exp_i      (exp_q),
    .addr_i     (addr_q),
    .dout_i     (MEM_DOUT),
    .fail_o     (FAIL),
    .fail_addr_o(FAIL_ADDR),
    .err_count_o(ERR_COUNT)
  );

  assign MEM_ADDR = addr_q;
  assign MEM_DIN  = din_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: doc/mem_bist.md
# mem_bist

Built-in self-test sequencer that sits directly upstream of the synchronous single-port `memory` block. It drives that block's address and data-in, and consumes its registered data-out. A 4-sweep march test (fill, ascending invert, descending restore, ascending verify) runs on a `START` pulse and reports pass/fail, the first failing address and an error count. The design accounts for the memory's write-every-cycle, read-old-data behaviour: every read re-writes a known value, and `DOUT` of a location presented at edge k is valid after edge k+1.

## Interface
- `WORD_SIZE`, default 8: data width; must match the memory's `wordSize`.
- `ADDR_SIZE`, default 4: address width; depth N = 2^ADDR_SIZE.
- `PATTERN`, default 8'h55 (truncated/zero-extended to `WORD_SIZE`): background pattern P; ~P is the inverted background.
- `ERR_WIDTH`, default 8: width of the error counter.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: begin test; sampled only in IDLE or DONE.
- `MEM_ADDR` out `ADDR_SIZE`: address to memory `ADDR`; registered.
- `MEM_DIN` out `WORD_SIZE`: write data to memory `DIN`; registered.
- `MEM_DOUT` in `WORD_SIZE`: memory `DOUT`.
- `BUSY` out 1: test in progress.
- `DONE` out 1: test complete; held until next `START` or `RST`.
- `FAIL` out 1: sticky mismatch flag.
- `FAIL_ADDR` out `ADDR_SIZE`: address of first mismatch.
- `ERR_COUNT` out `ERR_WIDTH`: saturating mismatch count.

## Operation
- States: IDLE, FILL, M1_UP, M2_DN, VERIFY, FLUSH, DONE.
- IDLE/DONE with `START`=1: clear `FAIL`, `FAIL_ADDR`, `ERR_COUNT` and `DONE`; set `BUSY`; go to FILL with `MEM_ADDR`=0.
- FILL: addresses 0..N-1, DIN=P, no check, because prior contents are unknown.
- M1_UP: addresses 0..N-1, DIN=~P, expect P.
- M2_DN: addresses N-1..0, DIN=P, expect ~P. The first M2_DN address equals the last M1_UP address on consecutive cycles, which is legal: the memory returns the value written one edge earlier.
- VERIFY: addresses 0..N-1, DIN=P, expect P.
- FLUSH: 1 cycle. `MEM_ADDR`/`MEM_DIN` hold (re-writes P harmlessly) while the last compare retires. Then go to DONE: `BUSY`=0, `DONE`=1.
- Each sweep ends when the address counter reaches its terminal value (N-1 ascending, 0 descending). There is no wrap into the next sweep without a state change.
- Check pipeline: expected value, check-enable and address are delayed 1 cycle to align with `MEM_DOUT`. The compare result is registered on the following edge.
- On mismatch: set `FAIL`; load `FAIL_ADDR` only if `FAIL` was 0; increment `ERR_COUNT`, saturating at all-ones.
- `START` while `BUSY` is ignored.
- `RST` has priority over everything, including mid-sweep and same-edge `START`. All state and outputs clear; memory contents are not touched.

## Timing
- Reset values: `MEM_ADDR`=0, `MEM_DIN`=0, `BUSY`=0, `DONE`=0, `FAIL`=0, `FAIL_ADDR`=0, `ERR_COUNT`=0; state IDLE.
- With the `START`-sampling edge as e0, addresses are presented after:
  - FILL: e0..e(N-1)
  - M1: eN..e(2N-1)
  - M2: e2N..e(3N-1)
  - VERIFY: e3N..e(4N-1)
- FLUSH follows e4N.
- After e(4N+1): `DONE`=1, `BUSY`=0, and the final `FAIL`/`ERR_COUNT` are valid on the same edge.
- Total latency: 4N+1 cycles. For N=16, that is 65.
- Compare latency: mismatch on address presented after edge k is reflected in `FAIL` after edge k+2.
- `BUSY` rises after e0 and falls with the `DONE` rise.

## Structure
- Shared package `mem_bist_pkg`:
  - state encoding localparams (IDLE..DONE, 3 bits)
  - sweep-direction constant
  - the FLUSH length (1)
- Top `mem_bist`: FSM, address counter (up/down) and `MEM_DIN` mux.
- Sub-module `mem_bist_checker`: expected/enable/address delay registers, comparator, sticky `FAIL`, first-address capture, saturating counter. Parameterised on `WORD_SIZE`, `ADDR_SIZE`, `ERR_WIDTH`.

## Test plan
The bench uses N=16, `WORD_SIZE`=8, P=8'h55, with `mem_bist` driving a fault-free memory model.

1. Good memory, 1-cycle `START` pulse → `DONE` 65 edges later, `FAIL`=0, `ERR_COUNT`=0, `BUSY` high exactly 65 cycles.
2. Sequence monitor → `MEM_ADDR` runs 0..15, 0..15, 15..0, 0..15. `MEM_DIN` runs 55, AA, 55, 55 per sweep. Same address (15) appears on the M1→M2 boundary cycles.
3. Inject stuck-at-0 on `MEM_DOUT` bit0 when address 5 is read → `FAIL`=1, `FAIL_ADDR`=5, `ERR_COUNT`=2 (M1 and VERIFY mismatch; M2 expects AA and passes).
4. Assert `RST` for 1 cycle at cycle 20 of a run → all outputs 0 on the next edge, no `DONE`. A new `START` completes in 65 cycles with `FAIL`=0.
5. Pulse `START` again at cycles 10 and 40 of a run → ignored; `DONE` still at 65.
6. After failing run (3), `START` again with fault removed → `FAIL`, `FAIL_ADDR`, `ERR_COUNT` clear after the `START` edge; the run ends `FAIL`=0.
